// File: rtl/song_reader.sv
// song_reader: walks one song of the song ROM and hands {note, duration}
// words to note_player one at a time.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   play       level; high = run, low = freeze in place
//   song       song select (upper ROM address bits)
//   note_done  note_player has finished the current note
//   note       note number for note_player (registered)
//   duration   beat count for note_player (registered)
//   new_note   one-cycle load strobe for note_player (registered)
//   song_done  one-cycle pulse at end of song (registered)
//
// song_rom: synchronous-read ROM holding four 32-entry songs.
//   word = {note[5:0], duration[5:0]}; duration 0 marks end of song.

module song_rom #(
    parameter int SONG_BITS = 2,
    parameter int IDX_BITS  = 5
) (
    input  logic                          clk,
    input  logic [SONG_BITS+IDX_BITS-1:0] addr,
    output logic [11:0]                   dout
);

    function automatic logic [11:0] rom_word(input logic [SONG_BITS+IDX_BITS-1:0] a);
        logic [SONG_BITS-1:0] s;
        logic [IDX_BITS-1:0]  i;
        int unsigned          si;
        int unsigned          ii;
        logic [11:0]          word;
        {s, i} = a;
        si   = 32'(s);
        ii   = 32'(i);
        word = '0;
        if (si == 0) begin
            if (ii == 0)      word = {6'd10, 6'd4};
            else if (ii == 1) word = {6'd12, 6'd2};
        end else if (si == 1) begin
            // every entry nonzero: note = index+1, duration cycles 1..7
            word = {6'(ii + 1), 6'((ii % 7) + 1)};
        end else if (si == 2) begin
            if (ii == 0)      word = {6'd20, 6'd3};
            else if (ii == 1) word = {6'd22, 6'd5};
        end else begin
            if (ii == 0)      word = {6'd33, 6'd1};
        end
        return word;
    endfunction

    always_ff @(posedge clk) begin
        dout <= rom_word(addr);
    end

endmodule

module song_reader #(
    parameter int SONG_BITS     = 2,
    parameter int NOTE_IDX_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play,
    input  logic [SONG_BITS-1:0] song,
    input  logic                 note_done,
    output logic [5:0]           note,
    output logic [5:0]           duration,
    output logic                 new_note,
    output logic                 song_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [NOTE_IDX_BITS-1:0] LAST_IDX = '1;

    logic [2:0]                         state, state_nx;
    logic [NOTE_IDX_BITS-1:0]           index, index_nx;
    logic [SONG_BITS-1:0]               song_q, song_q_nx;
    logic [5:0]                         note_nx, duration_nx;
    logic                               new_note_nx, song_done_nx;
    logic                               hold_first, hold_first_nx;
    logic [SONG_BITS+NOTE_IDX_BITS-1:0] addr;
    logic [11:0]                        dout;

    // Address only moves with song_q/index, so a frozen FSM keeps dout valid.
    assign addr = {song_q, index};

    song_rom #(
        .SONG_BITS(SONG_BITS),
        .IDX_BITS (NOTE_IDX_BITS)
    ) u_song_rom (
        .clk (clk),
        .addr(addr),
        .dout(dout)
    );

    always_comb begin
        state_nx      = state;
        index_nx      = index;
        song_q_nx     = song_q;
        note_nx       = note;
        duration_nx   = duration;
        hold_first_nx = hold_first;
        new_note_nx   = 1'b0;
        song_done_nx  = 1'b0;

        if (state != IDLE && song != song_q) begin
            // song change abandons the current song silently
            state_nx = IDLE;
            index_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    song_q_nx = song;
                    index_nx  = '0;
                    if (play) state_nx = FETCH;
                end
                FETCH: begin
                    if (play) state_nx = LATCH;
                end
                LATCH: begin
                    if (play) begin
                        if (dout[5:0] == 6'd0) begin
                            state_nx     = DONE;
                            song_done_nx = 1'b1;
                        end else begin
                            note_nx       = dout[11:6];
                            duration_nx   = dout[5:0];
                            new_note_nx   = 1'b1;
                            hold_first_nx = 1'b1;
                            state_nx      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // The strobe cycle must elapse with play high before
                    // note_done counts; a done left over from the previous
                    // note is ignored there.
                    if (play) begin
                        if (hold_first) begin
                            hold_first_nx = 1'b0;
                        end else if (note_done) begin
                            if (index == LAST_IDX) begin
                                state_nx     = DONE;
                                song_done_nx = 1'b1;
                            end else begin
                                index_nx = index + 1'b1;
                                state_nx = FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                    index_nx = '0;
                end
                default: begin
                    state_nx = IDLE;
                    index_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            index      <= '0;
            song_q     <= '0;
            note       <= '0;
            duration   <= '0;
            new_note   <= 1'b0;
            song_done  <= 1'b0;
            hold_first <= 1'b0;
        end else begin
            state      <= state_nx;
            index      <= index_nx;
            song_q     <= song_q_nx;
            note       <= note_nx;
            duration   <= duration_nx;
            new_note   <= new_note_nx;
            song_done  <= song_done_nx;
            hold_first <= hold_first_nx;
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: a cycle model computes expected outputs from the
// song contents, checked every cycle, plus directed literal expectations.

module tb_song_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0;
    logic [1:0] song = 2'd0;
    logic       note_done = 1'b0;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    song_reader #(
        .SONG_BITS    (2),
        .NOTE_IDX_BITS(5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .play     (play),
        .song     (song),
        .note_done(note_done),
        .note     (note),
        .duration (duration),
        .new_note (new_note),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Song contents as documented for the ROM.
    function automatic logic [11:0] rom(input int s, input int i);
        if (s == 0) begin
            if (i == 0) return {6'd10, 6'd4};
            if (i == 1) return {6'd12, 6'd2};
            return 12'd0;
        end
        if (s == 1) return {6'(i + 1), 6'((i % 7) + 1)};
        if (s == 2) begin
            if (i == 0) return {6'd20, 6'd3};
            if (i == 1) return {6'd22, 6'd5};
            return 12'd0;
        end
        if (i == 0) return {6'd33, 6'd1};
        return 12'd0;
    endfunction

    // Model: idle / loading (countdown of fetch+read cycles) / holding / ending
    typedef enum int {M_IDLE, M_LOAD, M_HOLD, M_END} mode_t;
    mode_t      m_mode = M_IDLE;
    int         m_cnt = 0;
    int         m_idx = 0;
    int         m_song = 0;
    bit         m_fresh = 1'b0;
    logic [5:0] m_note = '0;
    logic [5:0] m_dur = '0;
    logic       m_new = 1'b0;
    logic       m_done = 1'b0;

    always @(posedge clk) begin : model
        logic [11:0] w;
        m_new  <= 1'b0;
        m_done <= 1'b0;
        if (reset) begin
            m_mode  <= M_IDLE;
            m_idx   <= 0;
            m_song  <= 0;
            m_note  <= '0;
            m_dur   <= '0;
            m_fresh <= 1'b0;
            m_cnt   <= 0;
        end else if (m_mode != M_IDLE && int'(song) != m_song) begin
            m_mode <= M_IDLE;
            m_idx  <= 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_song <= int'(song);
                    m_idx  <= 0;
                    if (play) begin
                        m_mode <= M_LOAD;
                        m_cnt  <= 2;
                    end
                end
                M_LOAD: if (play) begin
                    if (m_cnt == 2) begin
                        m_cnt <= 1;
                    end else begin
                        w = rom(m_song, m_idx);
                        if (w[5:0] == 6'd0) begin
                            m_mode <= M_END;
                            m_done <= 1'b1;
                        end else begin
                            m_note  <= w[11:6];
                            m_dur   <= w[5:0];
                            m_new   <= 1'b1;
                            m_fresh <= 1'b1;
                            m_mode  <= M_HOLD;
                        end
                    end
                end
                M_HOLD: if (play) begin
                    if (m_fresh) begin
                        m_fresh <= 1'b0;
                    end else if (note_done) begin
                        if (m_idx == 31) begin
                            m_mode <= M_END;
                            m_done <= 1'b1;
                        end else begin
                            m_idx  <= m_idx + 1;
                            m_mode <= M_LOAD;
                            m_cnt  <= 2;
                        end
                    end
                end
                default: begin
                    m_mode <= M_IDLE;
                    m_idx  <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_note", int'(note), int'(m_note));
            check("model_duration", int'(duration), int'(m_dur));
            check("model_new_note", int'(new_note), int'(m_new));
            check("model_song_done", int'(song_done), int'(m_done));
        end
    end

    task automatic wait_nn(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!new_note && n < limit);
    endtask

    task automatic wait_sd(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!song_done && n < limit);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int cnt;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_note", int'(note), 0);
        check("reset_duration", int'(duration), 0);
        check("reset_new_note", int'(new_note), 0);
        check("reset_song_done", int'(song_done), 0);
        reset    = 1'b0;
        check_en = 1'b1;

        // Song 0: two notes then end marker
        play = 1'b1;
        wait_nn(10, n);
        check("t1_start_latency", n, 3);
        check("t1_note0", int'(note), 10);
        check("t1_dur0", int'(duration), 4);
        @(negedge clk);
        note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
        wait_nn(10, n);
        check("t1_next_latency", n, 2);
        check("t1_note1", int'(note), 12);
        check("t1_dur1", int'(duration), 2);
        @(negedge clk);
        note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
        wait_sd(10, n);
        check("t1_done_latency", n, 2);
        play = 1'b0;
        @(negedge clk);
        check("t1_done_one_cycle", int'(song_done), 0);

        // Song 1: 32 notes with note_done tied high
        song      = 2'd1;
        note_done = 1'b1;
        play      = 1'b1;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (new_note) begin
                check("t2_note", int'(note), cnt + 1);
                check("t2_dur", int'(duration), (cnt % 7) + 1);
                cnt++;
            end
            if (song_done) break;
        end
        check("t2_pulses", cnt, 32);
        check("t2_song_done", int'(song_done), 1);
        play      = 1'b0;
        note_done = 1'b0;
        @(negedge clk);

        // Freeze during HOLD
        song = 2'd0;
        @(negedge clk);
        play = 1'b1;
        wait_nn(10, n);
        check("t3_start_latency", n, 3);
        play = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            note_done = (i % 3 == 0);
            @(negedge clk);
            if (new_note) cnt++;
        end
        note_done = 1'b0;
        check("t3_frozen_pulses", cnt, 0);
        check("t3_frozen_note", int'(note), 10);
        check("t3_frozen_dur", int'(duration), 4);
        play = 1'b1;
        @(negedge clk);
        note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
        wait_nn(10, n);
        check("t3_resume_latency", n, 2);
        check("t3_resume_note", int'(note), 12);

        // Song change coincident with note_done
        @(negedge clk);
        song      = 2'd2;
        note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
        check("t4_no_song_done", int'(song_done), 0);
        check("t4_no_new_note", int'(new_note), 0);
        wait_nn(10, n);
        check("t4_restart_latency", n, 3);
        check("t4_note", int'(note), 20);
        check("t4_dur", int'(duration), 3);

        // Reset while in LATCH of song 2 index 1
        @(negedge clk);
        note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        play  = 1'b0;
        @(negedge clk);
        check("t5_note", int'(note), 0);
        check("t5_dur", int'(duration), 0);
        check("t5_new_note", int'(new_note), 0);
        check("t5_song_done", int'(song_done), 0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (new_note) cnt++;
        end
        check("t5_no_strobe", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
